// File: rtl/player_hit_if.sv
// Per-pixel collision inputs and per-frame hit/kill/invulnerability outputs exchanged
// between the frame timing/sprite logic and the player hit detector.
interface player_hit_if #(
    parameter int unsigned NUM_SHOTS = 4
);
    logic                 startOfFrame;
    logic                 playGame;
    logic                 playerDR;
    logic [NUM_SHOTS-1:0] shotDR;
    logic                 shotHitPlayer;
    logic [NUM_SHOTS-1:0] shotKill;
    logic                 invulnerable;
    logic                 playerBlink;

    modport master (
        output startOfFrame, playGame, playerDR, shotDR,
        input  shotHitPlayer, shotKill, invulnerable, playerBlink
    );

    modport slave (
        input  startOfFrame, playGame, playerDR, shotDR,
        output shotHitPlayer, shotKill, invulnerable, playerBlink
    );
endinterface

// File: rtl/player_hit_detector.sv
// Aggregates player/alien-shot pixel overlaps per frame into at most one hit pulse,
// a shot-kill mask, and a frame-counted invulnerability window with blink.
module player_hit_detector #(
    parameter int unsigned NUM_SHOTS     = 4,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 4,
    parameter int unsigned CNT_W         = 8
) (
    input logic         clk,
    input logic         resetN,
    player_hit_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StArmed, StInvuln} state_e;

    state_e               state_q, state_d;
    logic [NUM_SHOTS-1:0] coll;
    logic [NUM_SHOTS-1:0] kill_acc_q, kill_acc_d;
    logic [NUM_SHOTS-1:0] shot_kill_q, shot_kill_d;
    logic                 hit_acc_q, hit_acc_d;
    logic                 hit_q, hit_d;
    logic                 blink_q, blink_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0]     frame_dec, blink_dec;
    logic                 sof;

    assign sof       = bus_io.startOfFrame;
    assign coll      = bus_io.playerDR ? bus_io.shotDR : '0;
    assign frame_dec = (frame_cnt_q == '0) ? '0 : frame_cnt_q - CNT_W'(1);
    assign blink_dec = (blink_cnt_q == '0) ? '0 : blink_cnt_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        kill_acc_d  = kill_acc_q;
        hit_acc_d   = hit_acc_q;
        shot_kill_d = '0;
        hit_d       = 1'b0;
        blink_d     = blink_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;

        if (!bus_io.playGame) begin
            state_d     = StIdle;
            kill_acc_d  = '0;
            hit_acc_d   = 1'b0;
            blink_d     = 1'b0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (sof && hit_acc_q) begin
                        state_d     = StInvuln;
                        frame_cnt_d = CNT_W'(INVULN_FRAMES);
                        blink_cnt_d = CNT_W'(BLINK_FRAMES);
                        blink_d     = 1'b1;
                    end
                end
                StInvuln: begin
                    if (sof) begin
                        frame_cnt_d = frame_dec;
                        blink_cnt_d = blink_dec;
                        if (blink_dec == '0) begin
                            blink_d     = ~blink_q;
                            blink_cnt_d = CNT_W'(BLINK_FRAMES);
                        end
                        if (frame_dec == '0) begin
                            state_d     = StArmed;
                            blink_d     = 1'b0;
                            blink_cnt_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            // A collision on the boundary cycle belongs to the new frame, judged by its state.
            if (state_q != StIdle) begin
                if (sof) begin
                    shot_kill_d = kill_acc_q;
                    hit_d       = hit_acc_q;
                    kill_acc_d  = coll;
                    hit_acc_d   = (|coll) && (state_d == StArmed);
                end else begin
                    kill_acc_d  = kill_acc_q | coll;
                    hit_acc_d   = hit_acc_q | ((|coll) && (state_q == StArmed));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            kill_acc_q  <= '0;
            hit_acc_q   <= 1'b0;
            shot_kill_q <= '0;
            hit_q       <= 1'b0;
            blink_q     <= 1'b0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kill_acc_q  <= kill_acc_d;
            hit_acc_q   <= hit_acc_d;
            shot_kill_q <= shot_kill_d;
            hit_q       <= hit_d;
            blink_q     <= blink_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus_io.shotHitPlayer = hit_q;
    assign bus_io.shotKill      = shot_kill_q;
    assign bus_io.invulnerable  = (state_q == StInvuln);
    assign bus_io.playerBlink   = blink_q;

endmodule

// File: tb/tb_player_hit_detector.sv
// Bench for player_hit_detector: frame-numbered reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_player_hit_detector;
    localparam int NS = 4;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    player_hit_if #(.NUM_SHOTS(NS)) bus ();

    player_hit_detector #(
        .NUM_SHOTS    (NS),
        .INVULN_FRAMES(60),
        .BLINK_FRAMES (4),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: frames are numbered; a hit reported at the start of frame H makes frames
    // H..H+59 invulnerable, and blink is on during the even 4-frame groups of that window.
    bit          m_run, m_has_hit, m_inv, m_fhit, m_exp_hit;
    logic [NS-1:0] m_fkill, m_exp_kill, m_coll;
    int          m_frame, m_hit_frame;

    task automatic model_clear();
        m_run = 0; m_has_hit = 0; m_inv = 0; m_fhit = 0; m_exp_hit = 0;
        m_fkill = '0; m_exp_kill = '0; m_frame = 0; m_hit_frame = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN || !bus.playGame) begin
                model_clear();
            end else if (!m_run) begin
                model_clear();
                m_run = 1;
            end else begin
                m_coll = bus.playerDR ? bus.shotDR : '0;
                if (bus.startOfFrame) begin
                    m_exp_kill = m_fkill;
                    m_exp_hit  = m_fhit;
                    m_frame++;
                    if (m_fhit) begin
                        m_has_hit   = 1;
                        m_hit_frame = m_frame;
                    end
                    m_inv   = m_has_hit && ((m_frame - m_hit_frame) < 60);
                    m_fkill = m_coll;
                    m_fhit  = (|m_coll) && !m_inv;
                end else begin
                    m_exp_kill = '0;
                    m_exp_hit  = 0;
                    m_fkill    = m_fkill | m_coll;
                    m_fhit     = m_fhit | ((|m_coll) && !m_inv);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_hit",   bus.shotHitPlayer, m_exp_hit);
            chk("model_kill",  bus.shotKill, m_exp_kill);
            chk("model_inv",   bus.invulnerable, m_inv);
            chk("model_blink", bus.playerBlink,
                m_inv && (((m_frame - m_hit_frame) / 4) % 2 == 0));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic pix(input logic [NS-1:0] s, input int n);
        bus.playerDR = 1'b1;
        bus.shotDR   = s;
        tick(n);
        bus.playerDR = 1'b0;
        bus.shotDR   = '0;
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.playGame     = 1'b0;
        bus.playerDR     = 1'b0;
        bus.shotDR       = '0;
        tick(3);
        chk("rst_hit",   bus.shotHitPlayer, 0);
        chk("rst_kill",  bus.shotKill, 0);
        chk("rst_inv",   bus.invulnerable, 0);
        chk("rst_blink", bus.playerBlink, 0);
        resetN = 1'b1;
        tick();
        bus.playGame = 1'b1;
        tick(2);

        // Single shot overlapping for three pixels
        sof();
        tick(2);
        pix(4'b0100, 3);
        tick(3);
        sof();
        chk("s1_hit",   bus.shotHitPlayer, 1);
        chk("s1_kill",  bus.shotKill, 4'b0100);
        chk("s1_inv",   bus.invulnerable, 1);
        chk("s1_blink", bus.playerBlink, 1);
        tick();
        chk("s1_hit_end",  bus.shotHitPlayer, 0);
        chk("s1_kill_end", bus.shotKill, 0);
        tick(4);

        // Invulnerability window: kill-only report, blink period, release after 60 frames
        for (int k = 1; k <= 60; k++) begin
            sof();
            if (k == 11) begin
                chk("s3_kill", bus.shotKill, 4'b0010);
                chk("s3_nohit", bus.shotHitPlayer, 0);
            end
            if (k == 4)  chk("s3_blink4", bus.playerBlink, 0);
            if (k == 8)  chk("s3_blink8", bus.playerBlink, 1);
            if (k == 59) chk("s3_inv59", bus.invulnerable, 1);
            if (k == 60) begin
                chk("s3_inv60", bus.invulnerable, 0);
                chk("s3_blink60", bus.playerBlink, 0);
            end
            tick(2);
            if (k == 10) pix(4'b0010, 2);
            tick(4);
        end

        // Two shots in one frame
        pix(4'b0001, 2);
        tick(2);
        pix(4'b1000, 2);
        tick();
        sof();
        chk("s2_hit",  bus.shotHitPlayer, 1);
        chk("s2_kill", bus.shotKill, 4'b1001);
        tick();
        chk("s2_single", bus.shotHitPlayer, 0);
        tick(3);

        bus.playGame = 1'b0;
        tick(2);
        chk("idle_inv", bus.invulnerable, 0);
        bus.playGame = 1'b1;
        tick(2);

        // Collision on the boundary cycle belongs to the new frame
        tick(3);
        bus.playerDR = 1'b1;
        bus.shotDR   = 4'b0001;
        sof();
        bus.playerDR = 1'b0;
        bus.shotDR   = '0;
        chk("s4_nohit",  bus.shotHitPlayer, 0);
        chk("s4_nokill", bus.shotKill, 0);
        tick(6);
        sof();
        chk("s4_hit",  bus.shotHitPlayer, 1);
        chk("s4_kill", bus.shotKill, 4'b0001);
        chk("s4_inv",  bus.invulnerable, 1);

        // Pending report dropped when the game stops
        bus.playGame = 1'b0;
        tick();
        bus.playGame = 1'b1;
        tick(2);
        sof();
        tick(2);
        pix(4'b0100, 2);
        bus.playGame = 1'b0;
        tick(2);
        chk("s5_idle_inv", bus.invulnerable, 0);
        bus.playGame = 1'b1;
        tick(2);
        sof();
        chk("s5_nohit",  bus.shotHitPlayer, 0);
        chk("s5_nokill", bus.shotKill, 0);
        tick();
        pix(4'b0010, 1);
        tick(2);
        sof();
        chk("s5_armed_hit", bus.shotHitPlayer, 1);
        chk("s5_armed_kill", bus.shotKill, 4'b0010);

        // Asynchronous reset halfway through the window
        for (int k = 0; k < 30; k++) begin
            tick(4);
            sof();
        end
        tick(2);
        chk("s6_inv_before", bus.invulnerable, 1);
        @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("s6_hit",   bus.shotHitPlayer, 0);
        chk("s6_kill",  bus.shotKill, 0);
        chk("s6_inv",   bus.invulnerable, 0);
        chk("s6_blink", bus.playerBlink, 0);
        tick(2);
        resetN = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
